// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, stalls the pipeline while a
// request is outstanding and registers the result toward the memory2writeback register.
module memory_access #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dest_addr,
  input  logic        write_or_not,
  input  logic [31:0] wdata,
  input  logic [7:0]  aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] regOp2,
  input  logic        HILO_enabler,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  wb_dest_addr,
  output logic        wb_write,
  output logic [31:0] wb_wdata,
  output logic        wb_HILO_enabler,
  output logic [31:0] wb_HI,
  output logic [31:0] wb_LO,
  output logic        misalign,
  output logic        bus_error,
  output logic [31:0] bad_addr
);

  localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;

  logic            w_is_mem;
  logic            w_is_store;
  logic            w_signed;
  logic [1:0]      w_size;
  logic            w_misalign;
  logic [3:0]      w_sel;
  logic [31:0]     w_store_data;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_data;
  logic            w_last;

  // Opcode decode: access size, direction and extension
  always_comb begin
    w_is_mem   = 1'b1;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = SZ_WORD;
    case (aluop)
      8'h20: begin w_size = SZ_BYTE; w_signed = 1'b1; end
      8'h21: begin w_size = SZ_HALF; w_signed = 1'b1; end
      8'h23: w_size = SZ_WORD;
      8'h24: w_size = SZ_BYTE;
      8'h25: w_size = SZ_HALF;
      8'h28: begin w_size = SZ_BYTE; w_is_store = 1'b1; end
      8'h29: begin w_size = SZ_HALF; w_is_store = 1'b1; end
      8'h2B: begin w_size = SZ_WORD; w_is_store = 1'b1; end
      default: w_is_mem = 1'b0;
    endcase
  end

  assign w_misalign = ((w_size == SZ_HALF) && mem_addr[0]) ||
                      ((w_size == SZ_WORD) && (mem_addr[1:0] != 2'b00));

  // Byte enables and lane-replicated store data
  always_comb begin
    w_sel        = 4'b1111;
    w_store_data = regOp2;
    case (w_size)
      SZ_BYTE: begin
        w_sel        = 4'b0001 << mem_addr[1:0];
        w_store_data = {4{regOp2[7:0]}};
      end
      SZ_HALF: begin
        w_sel        = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{regOp2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction, little-endian
  assign w_byte = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = mem_rdata;
    case (w_size)
      SZ_BYTE: w_load_data = {{24{w_byte[7] & w_signed}}, w_byte};
      SZ_HALF: w_load_data = {{16{w_half[15] & w_signed}}, w_half};
      default: ;
    endcase
  end

  assign w_last    = (r_cnt == CNT_LAST);
  assign stall_req = (r_state == S_IDLE) ? (w_is_mem && !w_misalign)
                                         : (!mem_ack && !w_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_sel         <= '0;
      mem_addr_o      <= '0;
      mem_wdata       <= '0;
      wb_dest_addr    <= '0;
      wb_write        <= 1'b0;
      wb_wdata        <= '0;
      wb_HILO_enabler <= 1'b0;
      wb_HI           <= '0;
      wb_LO           <= '0;
      misalign        <= 1'b0;
      bus_error       <= 1'b0;
      bad_addr        <= '0;
    end else begin
      misalign  <= 1'b0;
      bus_error <= 1'b0;
      if (r_state == S_IDLE) begin
        if (!w_is_mem) begin
          wb_dest_addr    <= dest_addr;
          wb_write        <= write_or_not;
          wb_wdata        <= wdata;
          wb_HILO_enabler <= HILO_enabler;
          wb_HI           <= HI;
          wb_LO           <= LO;
        end else if (w_misalign) begin
          misalign        <= 1'b1;
          bad_addr        <= mem_addr;
          wb_write        <= 1'b0;
          wb_HILO_enabler <= 1'b0;
        end else begin
          mem_req         <= 1'b1;
          mem_we          <= w_is_store;
          mem_sel         <= w_sel;
          mem_addr_o      <= {mem_addr[31:2], 2'b00};
          mem_wdata       <= w_store_data;
          wb_write        <= 1'b0;
          wb_HILO_enabler <= 1'b0;
          r_cnt           <= '0;
          r_state         <= S_BUSY;
        end
      end else begin
        // Ack in the final cycle takes priority over the timeout abort
        if (mem_ack) begin
          mem_req         <= 1'b0;
          mem_we          <= 1'b0;
          wb_dest_addr    <= dest_addr;
          wb_write        <= write_or_not;
          wb_wdata        <= w_is_store ? wdata : w_load_data;
          wb_HILO_enabler <= HILO_enabler;
          wb_HI           <= HI;
          wb_LO           <= LO;
          r_state         <= S_IDLE;
        end else if (w_last) begin
          mem_req         <= 1'b0;
          mem_we          <= 1'b0;
          bus_error       <= 1'b1;
          bad_addr        <= mem_addr;
          wb_write        <= 1'b0;
          wb_HILO_enabler <= 1'b0;
          r_state         <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
